// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven_seg_scan display driver: segment patterns
// (active-low abcdefg) and the scan phase encoding.
package seven_seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   typedef enum logic {
      PH_DEAD = 1'b0,
      PH_ON   = 1'b1
   } phase_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment (abcdefg) decoder.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] hex_in,
   output logic [6:0] seg_out
);

   always_comb begin
      seg_out = SEG_OFF;
      case (hex_in)
         4'h0: seg_out = SEG_0;
         4'h1: seg_out = SEG_1;
         4'h2: seg_out = SEG_2;
         4'h3: seg_out = SEG_3;
         4'h4: seg_out = SEG_4;
         4'h5: seg_out = SEG_5;
         4'h6: seg_out = SEG_6;
         4'h7: seg_out = SEG_7;
         4'h8: seg_out = SEG_8;
         4'h9: seg_out = SEG_9;
         4'hA: seg_out = SEG_A;
         4'hB: seg_out = SEG_B;
         4'hC: seg_out = SEG_C;
         4'hD: seg_out = SEG_D;
         4'hE: seg_out = SEG_E;
         4'hF: seg_out = SEG_F;
         default: seg_out = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with dead time and
// frame-synchronous display update. Define SEVEN_SEG_SCAN_DP_EN for decimal points.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int REFRESH_CYCLES = 16,
   parameter int DEAD_CYCLES    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data_in,
`ifdef SEVEN_SEG_SCAN_DP_EN
   input  logic [DIGITS-1:0]     dp_in,
   output logic                  dp_out,
`endif
   input  logic                  load,
   input  logic [DIGITS-1:0]     blank_mask,
   output logic [DIGITS-1:0]     an_out,
   output logic [6:0]            seg_out,
   output logic                  frame_tick
);

   localparam int CNT_MAX = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] ON_LAST   = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
   localparam phase_e        PH_RST    = (DEAD_CYCLES == 0) ? PH_ON : PH_DEAD;

   phase_e               phase_q, phase_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [4*DIGITS-1:0]  shadow_q, shadow_d;
   logic [4*DIGITS-1:0]  display_q, display_d;
   logic                 pending_q, pending_d;
   logic                 blank_q, blank_d;
   logic [DIGITS-1:0]    an_q, an_d;
   logic [6:0]           seg_q, seg_d;
   logic                 tick_q, tick_d;

   logic                 slot_end, dead_end, wrap, enter_on, lit;
   logic [3:0]           digit_sel;
   logic [6:0]           seg_dec;
   logic [3:0]           disp_digit [DIGITS];

`ifdef SEVEN_SEG_SCAN_DP_EN
   logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
   logic [DIGITS-1:0]    display_dp_q, display_dp_d;
   logic                 dp_q, dp_d;
`endif

   // Outputs are decoded from next-state values so they change on the entry edge.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign disp_digit[gi] = display_d[4*gi +: 4];
   end

   assign digit_sel = disp_digit[idx_d];

   hex_to_seg u_hex_to_seg (
      .hex_in  (digit_sel),
      .seg_out (seg_dec)
   );

   always_comb begin
      slot_end = (phase_q == PH_ON) && (cnt_q == ON_LAST);
      dead_end = (phase_q == PH_DEAD) && (cnt_q == DEAD_LAST);
      wrap     = slot_end && (idx_q == IDX_LAST);

      phase_d = phase_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CW'(1);
      if (dead_end) begin
         phase_d = PH_ON;
         cnt_d   = '0;
      end else if (slot_end) begin
         phase_d = (DEAD_CYCLES == 0) ? PH_ON : PH_DEAD;
         cnt_d   = '0;
         idx_d   = wrap ? '0 : idx_q + IW'(1);
      end

      // The blank decision is frozen for the whole ON slot.
      enter_on = dead_end || (slot_end && (DEAD_CYCLES == 0));
      blank_d  = enter_on ? blank_mask[idx_d] : blank_q;

      shadow_d  = shadow_q;
      display_d = display_q;
      pending_d = pending_q;
      if (wrap) begin
         if (load) begin
            shadow_d  = data_in;
            display_d = data_in;
         end else if (pending_q) begin
            display_d = shadow_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         shadow_d  = data_in;
         pending_d = 1'b1;
      end

      lit  = (phase_d == PH_ON) && !blank_d;
      an_d = '1;
      if (lit) begin
         an_d[idx_d] = 1'b0;
      end
      seg_d  = lit ? seg_dec : SEG_OFF;
      tick_d = wrap;
   end

`ifdef SEVEN_SEG_SCAN_DP_EN
   always_comb begin
      shadow_dp_d  = shadow_dp_q;
      display_dp_d = display_dp_q;
      if (wrap) begin
         if (load) begin
            shadow_dp_d  = dp_in;
            display_dp_d = dp_in;
         end else if (pending_q) begin
            display_dp_d = shadow_dp_q;
         end
      end else if (load) begin
         shadow_dp_d = dp_in;
      end
      dp_d = lit ? ~display_dp_d[idx_d] : 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q   <= PH_RST;
         idx_q     <= '0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         display_q <= '0;
         pending_q <= 1'b0;
         blank_q   <= 1'b0;
         an_q      <= '1;
         seg_q     <= SEG_OFF;
         tick_q    <= 1'b0;
`ifdef SEVEN_SEG_SCAN_DP_EN
         shadow_dp_q  <= '0;
         display_dp_q <= '0;
         dp_q         <= 1'b1;
`endif
      end else begin
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         display_q <= display_d;
         pending_q <= pending_d;
         blank_q   <= blank_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         tick_q    <= tick_d;
`ifdef SEVEN_SEG_SCAN_DP_EN
         shadow_dp_q  <= shadow_dp_d;
         display_dp_q <= display_dp_d;
         dp_q         <= dp_d;
`endif
      end
   end

   assign an_out     = an_q;
   assign seg_out    = seg_q;
   assign frame_tick = tick_q;
`ifdef SEVEN_SEG_SCAN_DP_EN
   assign dp_out     = dp_q;
`endif

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Multi-digit, time-multiplexed driver for common-anode 7-segment displays. It is the parametrised successor to the single-digit hex-to-7-segment decoder.
- Latches a packed hex word and scans the digits one at a time. Anodes are inactive during a programmable dead time between digits, to suppress ghosting.
- Display data updates only at frame boundaries, so no digit ever shows a mix of old and new values.
- Sits between board-level control logic and the display anode/segment pins.

Parameters:
- DIGITS, 4: number of digits; legal range 1..8.
- REFRESH_CYCLES, 16: clk cycles each digit is lit; must be >= 1.
- DEAD_CYCLES, 2: clk cycles with all anodes off before each digit; 0 disables the dead phase.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  4*DIGITS  packed hex digits; digit k = data_in[4k+3:4k]; digit 0 is the rightmost digit.
- load  in  1  one-cycle strobe; captures data_in into the shadow register.
- blank_mask  in  DIGITS  bit k=1 keeps digit k dark during its slot.
- an_out  out  DIGITS  anode drives, active-low (0 = digit on).
- seg_out  out  7  segments {a,b,c,d,e,f,g} = seg_out[6:0], active-low.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, while reset=0):
  - Outputs: an_out = all 1s, seg_out = 7'h7F, frame_tick = 0.
  - Internal state: idx = 0, phase = DEAD (ON if DEAD_CYCLES=0), slot counter = 0, shadow = 0, display = 0, pending = 0.
  - Reset mid-scan aborts the scan immediately. Scanning restarts at digit 0 on the first edge after release.
- FSM states:
  - DEAD: lasts DEAD_CYCLES cycles. an_out is all 1s and seg_out is 7'h7F. Then go to ON.
  - ON: lasts REFRESH_CYCLES cycles.
    - If blank_mask[idx]=0: an_out[idx]=0 and seg_out = decode(display digit idx).
    - If blank_mask[idx]=1: outputs stay dark.
    - At the end of ON, idx increments and the FSM goes to DEAD. idx wraps from DIGITS-1 to 0.
- Output timing:
  - an_out and seg_out are registered. They change on the same edge that enters a phase, with no extra latency.
  - blank_mask is sampled on the edge entering ON. It is held for the whole slot.
- Frame timing:
  - Frame = DIGITS*(DEAD_CYCLES+REFRESH_CYCLES) cycles; 72 cycles with the defaults.
  - The boundary is the edge on which idx wraps to 0. On that edge frame_tick=1 for one cycle.
  - At the boundary, if pending=1: display <= shadow and pending <= 0.
- load:
  - On load, shadow <= data_in and pending <= 1.
  - Multiple loads within one frame: the last one wins.
  - load on the boundary edge: data_in goes straight to display and pending stays 0.
- DIGITS=1: the frame boundary occurs at every slot end.
- Decode table, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000

Optional Feature:
- Macro: SEVEN_SEG_SCAN_DP_EN.
- When defined:
  - Adds port dp_in [DIGITS-1:0], captured into shadow/display alongside data_in under the same load and boundary rules.
  - Adds port dp_out [1], active-low. dp_out = ~display_dp[idx] during a non-blanked ON slot, and 1 otherwise. Reset value is 1.
- When undefined: neither port exists and no decimal-point state is built.

Decomposition:
- Shared package seven_seg_pkg:
  - SEG_OFF = 7'h7F
  - the 16 hex segment constants
  - phase encoding (PH_DEAD, PH_ON)
- One combinational sub-module hex_to_seg: 4-bit in, 7-bit active-low out, implementing the decode table. It is instantiated once and fed by a mux on display digit idx.

Test Plan:
- Reset and release, defaults -> an_out=4'b1111 and seg_out=7'h7F during reset. First ON at cycle 2 shows an_out=4'b1110, seg_out=7'b0000001 (display=0). frame_tick at cycle 72.
- load data_in=16'h1234 at cycle 10 -> frame 0 still shows 0000. After the cycle-72 boundary, digit0 shows seg 1001100 with an_out=1110, and digit3 shows seg 1001111 with an_out=0111.
- Loads 16'hAAAA then 16'hBEEF within one frame -> only BEEF is displayed after the next boundary. Digit1 shows E=0110000.
- load asserted on the frame_tick edge with 16'hC0DE -> display updates that same edge, with no one-frame delay. Digit0 shows E, and pending remains 0.
- blank_mask=4'b0100 -> during digit 2's slot an_out=4'b1111 and seg_out=7'h7F. The other digits are unaffected and frame length is unchanged.
- reset pulsed low during digit 2's ON slot -> outputs go dark asynchronously, display is cleared to 0, and scanning restarts at digit 0 after release.
